alu_arbiter: RTL and testbench

Two-requester, round-robin arbiter that shares one 32-bit `alu` instance between independent clients, for example a fetch/branch unit and an execute unit. Each requester issues an operand/opcode transaction over a valid/ready handshake. The block sequences one ALU operation at a time and returns the registered result, zero and carry-out flags to the issuing requester over a second valid/ready handshake. It sits directly in front of `alu`, drives its `a`/`b`/`op` inputs and samples its `result`/`zero`/`cout` outputs.

---
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational 32-bit ALU.
// One operation in flight at a time: IDLE accepts, EXEC samples the ALU, RESP returns it.
module alu_arbiter #(
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_cout,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_cout,
  output logic        rsp1_err,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        cout_q, cout_d;
  logic        err_q, err_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_ready;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [3:0]  req_op [2];
  logic        win;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;
  assign req_op[0] = req0_op;
  assign req_op[1] = req1_op;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Under contention the requester not granted last time wins; otherwise whoever is valid.
  assign win = (&req_valid) ? ~last_q : req_valid[1];

  // Ready is combinational and masked by rst so it drops the instant reset asserts.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      localparam logic IDX = 1'(gi);
      assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && (win == IDX) && !rst;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          owner_d = win;
          a_d     = req_a[win];
          b_d     = req_b[win];
          op_d    = req_op[win];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu_result;
        zero_d      = alu_zero;
        cout_d      = alu_cout;
        err_d       = !op_legal(op_q);
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_d      = owner_q;
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= ~FIRST_PRI;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;

  // Both response ports share one register set; qualify with rspN_valid.
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_cout   = cout_q;
  assign rsp0_err    = err_q;

  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = res_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_cout   = cout_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural combinational ALU on the alu_* port.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp0_cout, rsp0_err, rsp1_zero, rsp1_cout, rsp1_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_cout;
  logic [32:0] alu_sum;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  always #5 clk = ~clk;

  alu_arbiter #(.FIRST_PRI(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_cout(rsp0_cout), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_cout(rsp1_cout), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  // ALU: op[2] inverts b and injects carry-in; cout is always the adder carry.
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, (alu_op[2] ? ~alu_b : alu_b)} + {32'd0, alu_op[2]};
    case (alu_op)
      OP_AND:         alu_result = alu_a & alu_b;
      OP_OR:          alu_result = alu_a | alu_b;
      OP_ADD, OP_SUB: alu_result = alu_sum[31:0];
      OP_SLT:         alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default:        alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
    alu_cout = alu_sum[32];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
    if (r == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Single transaction from requester r, starting 1ns after the edge of an IDLE cycle T.
  task automatic txn(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] er, input logic ez, input logic ec,
                     input logic ee);
    drive_req(r, 1'b1, a, b, op);
    #1;
    chk({tag, ".ready_T"}, (r == 0) ? req0_ready : req1_ready, 1);
    step();
    drive_req(r, 1'b0, 32'd0, 32'd0, 4'd0);
    chk({tag, ".rspv_T1"}, {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, op});
    step();
    chk({tag, ".rspv_T2"}, {30'd0, rsp1_valid, rsp0_valid}, (r == 0) ? 1 : 2);
    chk({tag, ".result"}, (r == 0) ? rsp0_result : rsp1_result, er);
    chk({tag, ".zero"}, (r == 0) ? rsp0_zero : rsp1_zero, ez);
    chk({tag, ".cout"}, (r == 0) ? rsp0_cout : rsp1_cout, ec);
    chk({tag, ".err"}, (r == 0) ? rsp0_err : rsp1_err, ee);
    $display("[TB] txn %s req%0d op=%b a=%08h b=%08h result=%08h", tag, r, op, a, b,
             (r == 0) ? rsp0_result : rsp1_result);
    step();
    chk({tag, ".rspv_T3"}, {30'd0, rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 32'd1, 32'd2, OP_ADD);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state, with a valid request held during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req0_ready", req0_ready, 0);
    chk("rst.rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rst.result", rsp0_result, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_op", {28'd0, alu_op}, 0);
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;
    step();

    // Single-requester operations
    txn("add",   0, 32'd5,        32'd7,        OP_ADD, 32'd12,       1'b0, 1'b0, 1'b0);
    txn("and",   0, 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, 1'b0, 1'b1, 1'b0);
    txn("sub",   1, 32'd3,        32'd3,        OP_SUB, 32'd0,        1'b1, 1'b1, 1'b0);
    txn("slt_t", 1, 32'hFFFFFFFF, 32'd1,        OP_SLT, 32'd1,        1'b0, 1'b1, 1'b0);
    txn("slt_f", 1, 32'd1,        32'hFFFFFFFF, OP_SLT, 32'd0,        1'b1, 1'b0, 1'b0);

    // Contention: last grant was req1, so grants run 0,1,0,1,...
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_a = k; req0_b = 32'h100; req0_op = OP_ADD;
      req1_a = k; req1_b = 32'h200; req1_op = OP_ADD;
      #1;
      chk($sformatf("cont%0d.ready0", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d.ready1", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      step();
      if (k == 6) req0_valid = 1'b0;
      if (k == 7) req1_valid = 1'b0;
      chk($sformatf("cont%0d.exec_ready", k), {30'd0, req1_ready, req0_ready}, 0);
      step();
      chk($sformatf("cont%0d.rspv", k), {30'd0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 1 : 2);
      chk($sformatf("cont%0d.result", k), (k % 2 == 0) ? rsp0_result : rsp1_result,
          (k % 2 == 0) ? 32'h100 + k : 32'h200 + k);
      chk($sformatf("cont%0d.resp_ready", k), {30'd0, req1_ready, req0_ready}, 0);
      $display("[TB] txn cont%0d req%0d result=%08h", k, k % 2, (k % 2 == 0) ? rsp0_result : rsp1_result);
      step();
    end

    // Backpressure on rsp0 while req1 waits
    rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 32'd1, 32'd2, OP_ADD);
    drive_req(1, 1'b1, 32'hA0, 32'h0B, OP_OR);
    #1;
    chk("bp.ready0", req0_ready, 1);
    chk("bp.ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    chk("bp.exec_ready1", req1_ready, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d.rsp0_valid", k), rsp0_valid, 1);
      chk($sformatf("bp%0d.result", k), rsp0_result, 32'd3);
      chk($sformatf("bp%0d.flags", k), {29'd0, rsp0_zero, rsp0_cout, rsp0_err}, 0);
      chk($sformatf("bp%0d.ready1", k), req1_ready, 0);
      step();
    end
    chk("bp.held_valid", rsp0_valid, 1);
    rsp0_ready = 1'b1;
    $display("[TB] txn bp req0 result=%08h", rsp0_result);
    step();
    chk("bp.after_rspv", rsp0_valid, 0);
    req1_valid = 1'b0;
    txn("bp_or", 1, 32'hA0, 32'h0B, OP_OR, 32'hAB, 1'b0, 1'b0, 1'b0);

    // Illegal opcode is forwarded and flagged
    txn("illegal", 0, 32'd9, 32'd9, 4'b0101, 32'd0, 1'b1, 1'b1, 1'b1);
    txn("post_ill", 0, 32'd2, 32'd2, OP_ADD, 32'd4, 1'b0, 1'b0, 1'b0);

    // Reset during EXEC
    drive_req(0, 1'b1, 32'h10, 32'h20, OP_ADD);
    #1;
    chk("rstx.ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    chk("rstx.alu_a_pre", alu_a, 32'h10);
    #2 rst = 1'b1;
    #1;
    chk("rstx.alu_a", alu_a, 0);
    chk("rstx.alu_b", alu_b, 0);
    chk("rstx.rspv", {30'd0, rsp1_valid, rsp0_valid}, 0);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rstx%0d.no_rsp", k), {30'd0, rsp1_valid, rsp0_valid}, 0);
    end

    // Reset during RESP
    drive_req(0, 1'b1, 32'h10, 32'h20, OP_ADD);
    step();
    req0_valid = 1'b0;
    step();
    chk("rstr.rsp_pre", rsp0_result, 32'h30);
    #2 rst = 1'b1;
    #1;
    chk("rstr.rsp0_valid", rsp0_valid, 0);
    chk("rstr.result", rsp0_result, 0);
    chk("rstr.flags", {29'd0, rsp0_zero, rsp0_cout, rsp0_err}, 0);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rstr%0d.no_rsp", k), {30'd0, rsp1_valid, rsp0_valid}, 0);
    end

    // After reset, contention goes to FIRST_PRI (req0) even though req0 was served last
    drive_req(0, 1'b1, 32'h6, 32'h3, OP_AND);
    drive_req(1, 1'b1, 32'h6, 32'h3, OP_OR);
    #1;
    chk("fp.ready0", req0_ready, 1);
    chk("fp.ready1", req1_ready, 0);
    req1_valid = 1'b0;
    txn("fp_and", 0, 32'h6, 32'h3, OP_AND, 32'h2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
